// File: rtl/scan_flush_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : scan_flush_scheduler
// Purpose  : Arbitrates the shared flush downlink between two scanners,
//            sequences flush pulse / wait / drain / release, relays the
//            standby and start-scan handoff, and guards against a scanner
//            that never enters the flushing state.
// Revision : 1.0 - initial release
// ============================================================================
module scan_flush_scheduler #(
  parameter int FLUSH_TO = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       state0,
  input  logic [2:0]       state1,
  input  logic [1:0]       rdy_flush,
  input  logic [1:0]       start_scan_out,
  input  logic [1:0]       goto_stby_out,
  input  logic             link_ready,
  output logic [1:0]       flush,
  output logic [1:0]       start_scan_in,
  output logic [1:0]       goto_stby_in,
  output logic [1:0]       grant,
  output logic             link_active,
  output logic [CNT_W-1:0] flush_count,
  output logic             err_timeout
);

  localparam logic [2:0] ST_LOW_PWR  = 3'b000;
  localparam logic [2:0] ST_STBY     = 3'b001;
  localparam logic [2:0] ST_SCANNING = 3'b010;
  localparam logic [2:0] ST_IDLE     = 3'b011;
  localparam logic [2:0] ST_FLUSHING = 3'b100;

  localparam logic [7:0]       TO_LAST = 8'(FLUSH_TO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;

  arb_state_t r_arb_state;
  logic       r_winner;      // scanner currently holding the channel
  logic       r_last_grant;  // scanner served most recently (tie-break)
  logic [7:0] r_to_cnt;

  logic [1:0] w_full_req;
  logic [1:0] w_soft_req;
  logic [1:0] w_class;
  logic       w_pick;
  logic [2:0] w_owner_state;

  // Request classification, priority pick and owner state lookup
  always_comb begin
    w_full_req[0] = (state0 == ST_IDLE);
    w_full_req[1] = (state1 == ST_IDLE);
    w_soft_req[0] = (state0 == ST_SCANNING) & rdy_flush[0];
    w_soft_req[1] = (state1 == ST_SCANNING) & rdy_flush[1];
    // Full requests shadow soft ones; within a class alternate on ties
    w_class       = (|w_full_req) ? w_full_req : w_soft_req;
    w_pick        = (w_class == 2'b11) ? ~r_last_grant : w_class[1];
    w_owner_state = r_winner ? state1 : state0;
  end

  // Arbiter: grant, one-cycle pulse, wait for flushing with timeout, drain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arb_state  <= ARB_IDLE;
      r_winner     <= 1'b0;
      r_last_grant <= 1'b1;
      r_to_cnt     <= 8'd0;
      flush        <= 2'b00;
      grant        <= 2'b00;
      link_active  <= 1'b0;
      flush_count  <= '0;
      err_timeout  <= 1'b0;
    end else begin
      case (r_arb_state)
        ARB_IDLE: begin
          flush <= 2'b00;
          if (link_ready && |w_class) begin
            r_winner    <= w_pick;
            grant       <= w_pick ? 2'b10 : 2'b01;
            flush       <= w_pick ? 2'b10 : 2'b01;
            r_arb_state <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // Pulse lasts exactly this cycle, regardless of the request now
          flush       <= 2'b00;
          r_to_cnt    <= 8'd0;
          r_arb_state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (w_owner_state == ST_FLUSHING) begin
            link_active <= 1'b1;
            r_arb_state <= ARB_DRAIN;
          end else if (r_to_cnt == TO_LAST) begin
            err_timeout  <= 1'b1;
            r_last_grant <= r_winner;
            grant        <= 2'b00;
            r_arb_state  <= ARB_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        ARB_DRAIN: begin
          // Leaving flushing for any state completes the session
          if (w_owner_state != ST_FLUSHING) begin
            flush_count  <= flush_count + CNT_ONE;
            r_last_grant <= r_winner;
            grant        <= 2'b00;
            link_active  <= 1'b0;
            r_arb_state  <= ARB_IDLE;
          end
        end
        default: begin
          flush       <= 2'b00;
          grant       <= 2'b00;
          link_active <= 1'b0;
          r_arb_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Peer handoff relay, one-cycle latency, independent of the arbiter
  always_ff @(posedge clk) begin
    if (reset) begin
      goto_stby_in  <= 2'b00;
      start_scan_in <= 2'b00;
    end else begin
      goto_stby_in[0]  <= (state0 == ST_LOW_PWR) & goto_stby_out[1];
      goto_stby_in[1]  <= (state1 == ST_LOW_PWR) & goto_stby_out[0];
      start_scan_in[0] <= (state0 == ST_STBY) & start_scan_out[1];
      start_scan_in[1] <= (state1 == ST_STBY) & start_scan_out[0];
    end
  end

endmodule
`default_nettype wire

// File: doc/scan_flush_scheduler.md
Name: scan_flush_scheduler

Overview:
- Sits between the primary and alternate scanners and the single shared downlink.
- Grants the flush channel to one scanner at a time and sequences its flush pulse, drain and release.
- Relays the standby and start-scan handoff between the two scanners.
- Provides a timeout guard and a completed-flush counter.

Parameters:
FLUSH_TO, 16, cycles allowed after a flush pulse for the granted scanner to report the flushing state (2..255)
CNT_W, 8, width of flush_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
state0  in  3  scanner 0 state (000 low_pwr, 001 stby, 010 scanning, 011 idle, 100 flushing)
state1  in  3  scanner 1 state, same encoding
rdy_flush  in  2  per-scanner ready-to-flush (bit i = scanner i)
start_scan_out  in  2  per-scanner start request to the peer
goto_stby_out  in  2  per-scanner standby request to the peer
link_ready  in  1  downlink can accept a new flush session
flush  out  2  one-cycle flush command to scanner i
start_scan_in  out  2  start command to scanner i
goto_stby_in  out  2  standby command to scanner i
grant  out  2  one-hot owner of the flush channel; 00 when free
link_active  out  1  a granted scanner is draining onto the downlink
flush_count  out  CNT_W  completed flush sessions, wraps at 2^CNT_W
err_timeout  out  1  sticky: a granted scanner failed to enter flushing

Behaviour:
- All outputs are registered. Reset values: flush=00, start_scan_in=00, goto_stby_in=00, grant=00, link_active=0, flush_count=0, err_timeout=0. Internal values on reset: FSM=ARB_IDLE, timeout counter=0, last_grant=1 (so scanner 0 wins the first tie).
- Reset mid-session abandons the session: no flush_count increment, no pulse issued.
- Request for scanner i:
  - full_req[i] = state_i==idle.
  - soft_req[i] = state_i==scanning & rdy_flush[i].
  - req[i] = full_req[i] | soft_req[i].
- Arbiter FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DRAIN.
- ARB_IDLE:
  - If link_ready=1 and any req, choose a winner:
    - full_req beats soft_req.
    - Within the same class, the scanner != last_grant wins.
    - A single requester always wins.
  - On a win: grant<=onehot(winner), go to ARB_ISSUE.
  - With link_ready=0, no grant is made and requests stay pending (requests are not latched; they are re-evaluated every cycle).
- ARB_ISSUE: exactly one cycle.
  - flush[winner]=1 during this cycle. flush is 00 in every other state and for the non-winner.
  - Go to ARB_WAIT with the counter cleared.
  - The pulse is issued even if the request dropped during the grant cycle.
- ARB_WAIT:
  - If state_winner==flushing: go to ARB_DRAIN.
  - Else if counter==FLUSH_TO-1: err_timeout<=1, last_grant<=winner, grant<=00, go to ARB_IDLE. flush_count is unchanged.
  - Else counter++.
  - Sequence: flush is asserted in ISSUE (cycle T), and flushing observed at cycle T+1 or later.
- ARB_DRAIN:
  - link_active=1.
  - When state_winner==low_pwr: flush_count++, last_grant<=winner, grant<=00, link_active<=0, go to ARB_IDLE.
  - Any other non-flushing state also ends the session the same way, including the flush_count increment.
  - link_ready is ignored while draining; it gates only new grants.
- Back-to-back sessions: a new grant may occur in the cycle after returning to ARB_IDLE. There is no dead cycle beyond that.
- Handoff logic is independent of the arbiter and updated every cycle:
  - goto_stby_in[i] <= state_i==low_pwr & goto_stby_out[1-i].
  - start_scan_in[i] <= state_i==stby & start_scan_out[1-i].
  - Latency is one cycle; these are level outputs that follow their inputs.
- Both scanners requesting simultaneously: only one grant. The loser's request is served after the current session finishes, if still present.
- err_timeout clears only on reset.

Test Plan:
- Reset, then state0=idle, state1=low_pwr, link_ready=1 -> grant=01 next cycle; flush=01 for exactly 1 cycle; state0=flushing -> link_active=1; state0=low_pwr -> grant=00, flush_count=1.
- Both scanners in idle simultaneously -> scanner 0 served first; after its drain, scanner 1 granted; flush_count=2; flush is never 11.
- state0=scanning with rdy_flush0=1, state1=idle, same cycle -> scanner 1 granted first (full beats soft).
- Granted scanner holds state=idle for 16 cycles after its pulse (FLUSH_TO=16) -> err_timeout=1, grant=00, flush_count unchanged, the other requester granted next.
- link_ready=0 with state0=idle for 10 cycles -> grant stays 00. Raise link_ready -> grant=01 next cycle. Drop link_ready mid-drain -> drain completes normally.
- state1=low_pwr and goto_stby_out[0]=1 -> goto_stby_in=10 one cycle later. state1=stby and start_scan_out[0]=1 -> start_scan_in=10 one cycle later. Assert reset mid-drain -> all outputs return to reset values on the next edge.
